// File: rtl/hazard1_mem_arbiter.sv
// hazard1_mem_arbiter
//
// Shares one single-ported, single-cycle SRAM between two masters. Master 0
// is the hazard1 core and master 1 is a second requester such as a loader or
// DMA. Requests are granted round-robin and the losing master is stalled.
// Read data is routed back to the master that issued the read. Each master's
// last read data is held, so a stalled master still samples a stable value.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   mN_addr  [W-1:0]    master N address
//   mN_wen   [3:0]      master N byte write enables
//   mN_ren              master N read enable
//   mN_wdata [W-1:0]    master N write data
//   mN_rdata [W-1:0]    master N read data (data phase or held value)
//   mN_stall            master N request not accepted this cycle
//   sram_addr/wen/ren/wdata   SRAM request, driven by the granted master or 0
//   sram_rdata          SRAM read data, valid the cycle after sram_ren
module hazard1_mem_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic [W-1:0] m0_addr,
    input  logic [3:0]   m0_wen,
    input  logic         m0_ren,
    input  logic [W-1:0] m0_wdata,
    output logic [W-1:0] m0_rdata,
    output logic         m0_stall,

    input  logic [W-1:0] m1_addr,
    input  logic [3:0]   m1_wen,
    input  logic         m1_ren,
    input  logic [W-1:0] m1_wdata,
    output logic [W-1:0] m1_rdata,
    output logic         m1_stall,

    output logic [W-1:0] sram_addr,
    output logic [3:0]   sram_wen,
    output logic         sram_ren,
    output logic [W-1:0] sram_wdata,
    input  logic [W-1:0] sram_rdata
);

    // Per-master views so the per-master logic can be generated once
    logic [W-1:0] addr_in  [2];
    logic [3:0]   wen_in   [2];
    logic         ren_in   [2];
    logic [W-1:0] wdata_in [2];
    logic [W-1:0] rdata_out[2];

    assign addr_in[0]  = m0_addr;
    assign addr_in[1]  = m1_addr;
    assign wen_in[0]   = m0_wen;
    assign wen_in[1]   = m1_wen;
    assign ren_in[0]   = m0_ren;
    assign ren_in[1]   = m1_ren;
    assign wdata_in[0] = m0_wdata;
    assign wdata_in[1] = m1_wdata;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       last_gnt_reg;
    logic       last_gnt_next;
    logic       dph_valid_reg;
    logic       dph_sel_reg;

    // Grant: a lone requester wins; under contention the master that was
    // not granted most recently wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt_reg ? 2'b01 : 2'b10;
        end
    end

    // last_gnt only moves on cycles that actually grant someone
    assign last_gnt_next = (|req) ? gnt[1] : last_gnt_reg;

    assign m0_stall = req[0] & ~gnt[0];
    assign m1_stall = req[1] & ~gnt[1];

    // SRAM drive: straight pass-through of the winner, all zero when idle.
    // Only request inputs feed this path; sram_rdata never does.
    always_comb begin
        sram_addr  = '0;
        sram_wen   = '0;
        sram_ren   = 1'b0;
        sram_wdata = '0;
        if (|gnt) begin
            sram_addr  = addr_in[gnt[1]];
            sram_wen   = wen_in[gnt[1]];
            sram_ren   = ren_in[gnt[1]];
            sram_wdata = wdata_in[gnt[1]];
        end
    end

    // Data-phase tracking. A read under reset still reaches the SRAM but
    // gets no data phase, so its data is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_reg  <= 1'b1;
            dph_valid_reg <= 1'b0;
            dph_sel_reg   <= 1'b0;
        end else begin
            last_gnt_reg  <= last_gnt_next;
            dph_valid_reg <= sram_ren;
            dph_sel_reg   <= gnt[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            localparam bit SEL = (gi == 1);

            logic         dph_mine;
            logic [W-1:0] hold_reg;

            assign req[gi]  = ren_in[gi] | (|wen_in[gi]);
            assign dph_mine = dph_valid_reg & (dph_sel_reg == SEL);

            // Hold the last returned word so it stays stable until this
            // master's next data phase, whatever the other master does.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                end else if (dph_mine) begin
                    hold_reg <= sram_rdata;
                end
            end

            assign rdata_out[gi] = dph_mine ? sram_rdata : hold_reg;
        end
    endgenerate

    assign m0_rdata = rdata_out[0];
    assign m1_rdata = rdata_out[1];

endmodule

// File: tb/tb_hazard1_mem_arbiter.sv
// Testbench for hazard1_mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_hazard1_mem_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  a  [2];
    logic [3:0]   we [2];
    logic         re [2];
    logic [31:0]  wd [2];

    logic [31:0]  m0_rdata, m1_rdata;
    logic         m0_stall, m1_stall;
    logic [31:0]  sram_addr, sram_wdata;
    logic [3:0]   sram_wen;
    logic         sram_ren;
    logic [31:0]  sram_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard1_mem_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_addr    (a[0]),
        .m0_wen     (we[0]),
        .m0_ren     (re[0]),
        .m0_wdata   (wd[0]),
        .m0_rdata   (m0_rdata),
        .m0_stall   (m0_stall),
        .m1_addr    (a[1]),
        .m1_wen     (we[1]),
        .m1_ren     (re[1]),
        .m1_wdata   (wd[1]),
        .m1_rdata   (m1_rdata),
        .m1_stall   (m1_stall),
        .sram_addr  (sram_addr),
        .sram_wen   (sram_wen),
        .sram_ren   (sram_ren),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // SRAM model: read-first, one cycle latency, garbage on idle cycles so a
    // wrongly captured data phase shows up. Backdoor port for preloading.
    logic [31:0] mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (sram_ren) sram_rdata <= mem[sram_addr[9:2]];
        else          sram_rdata <= $urandom;
        for (int b = 0; b < 4; b++)
            if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end

    // Reference model: who was granted last, memory contents, and the word
    // each master should currently see.
    int          ref_last;
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rdata [2];
    int          exp_win;
    logic        exp_stall [2];
    logic [31:0] exp_saddr, exp_swdata;
    logic [3:0]  exp_swen;
    logic        exp_sren;

    function automatic void ref_eval();
        bit r0 = re[0] || (we[0] != 4'h0);
        bit r1 = re[1] || (we[1] != 4'h0);
        if (r0 && r1)  exp_win = (ref_last == 0) ? 1 : 0;
        else if (r0)   exp_win = 0;
        else if (r1)   exp_win = 1;
        else           exp_win = -1;
        exp_stall[0] = r0 && (exp_win != 0);
        exp_stall[1] = r1 && (exp_win != 1);
        if (exp_win >= 0) begin
            exp_saddr  = a[exp_win];
            exp_swen   = we[exp_win];
            exp_sren   = re[exp_win];
            exp_swdata = wd[exp_win];
        end else begin
            exp_saddr  = '0;
            exp_swen   = '0;
            exp_sren   = 1'b0;
            exp_swdata = '0;
        end
    endfunction

    // Advance one clock and apply the transaction's effect to the model
    task automatic step();
        ref_eval();
        @(posedge clk);
        if (exp_win >= 0) begin
            int idx;
            idx = int'(a[exp_win][9:2]);
            if (rst_n && re[exp_win]) exp_rdata[exp_win] = ref_mem[idx];
            for (int b = 0; b < 4; b++)
                if (we[exp_win][b]) ref_mem[idx][8*b +: 8] = wd[exp_win][8*b +: 8];
            ref_last = exp_win;
            $display("txn t=%0t rst_n=%0b m%0d addr=%h wen=%h ren=%0b wdata=%h", $time, rst_n,
                     exp_win, a[exp_win], we[exp_win], re[exp_win], wd[exp_win]);
        end
        if (!rst_n) begin
            ref_last     = 1;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
        end
        #1;
    endtask

    task automatic drive(input int m, input logic [31:0] addr, input logic [3:0] wen,
                         input logic ren, input logic [31:0] wdata);
        a[m] = addr; we[m] = wen; re[m] = ren; wd[m] = wdata;
    endtask

    task automatic idle_all();
        drive(0, '0, '0, 1'b0, '0);
        drive(1, '0, '0, 1'b0, '0);
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        bd_we = 1'b1; bd_idx = 8'(idx); bd_data = data;
        ref_mem[idx] = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic preload();
        idle_all();
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) poke(i, $urandom);
        poke(8'h40, 32'hDEADBEEF);   // 0x100
        poke(8'h04, 32'h11111111);   // 0x010
        poke(8'h05, 32'h22222222);   // 0x014
        poke(8'h06, 32'h33333333);   // 0x018
        poke(8'h08, 32'h00000005);   // 0x020
        ref_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL reset_m0_rdata: got %h want %h", m0_rdata, 32'h0); end
        checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_m1_rdata: got %h want %h", m1_rdata, 32'h0); end
        checks++; if ({m0_stall, m1_stall} !== 2'b00) begin errors++; $display("FAIL reset_stalls: got %b want 00", {m0_stall, m1_stall}); end
        checks++; if ({sram_ren, sram_wen, sram_addr} !== '0) begin errors++; $display("FAIL reset_sram: got ren=%b wen=%h addr=%h want zeros", sram_ren, sram_wen, sram_addr); end
        step();
    endtask

    task automatic test_solo_read();
        idle_all();
        drive(0, 32'h100, 4'h0, 1'b1, '0);
        #1;
        checks++; if (m0_stall !== 1'b0) begin errors++; $display("FAIL solo_stall: got %b want 0", m0_stall); end
        checks++; if (sram_ren !== 1'b1 || sram_addr !== 32'h100) begin errors++; $display("FAIL solo_sram: got ren=%b addr=%h want ren=1 addr=00000100", sram_ren, sram_addr); end
        step();
        idle_all();
        #1;
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL solo_rdata: got %h want deadbeef", m0_rdata); end
        checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL solo_m1_rdata: got %h want 0", m1_rdata); end
        step();
        #1;
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL solo_hold: got %h want deadbeef", m0_rdata); end
        step();
    endtask

    task automatic test_contention();
        int k0 = 0, k1 = 0;
        idle_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a0, a1;
            a0 = 32'h200 + 32'(4 * k0);
            a1 = 32'h300 + 32'(4 * k1);
            drive(0, a0, 4'h0, 1'b1, '0);
            drive(1, a1, 4'h0, 1'b1, '0);
            #1;
            checks++; if (m0_stall !== (i % 2 == 1)) begin errors++; $display("FAIL cont_stall0 i=%0d: got %b want %b", i, m0_stall, (i % 2 == 1)); end
            checks++; if (m1_stall !== (i % 2 == 0)) begin errors++; $display("FAIL cont_stall1 i=%0d: got %b want %b", i, m1_stall, (i % 2 == 0)); end
            checks++; if (sram_addr !== ((i % 2 == 1) ? a1 : a0)) begin errors++; $display("FAIL cont_addr i=%0d: got %h want %h", i, sram_addr, (i % 2 == 1) ? a1 : a0); end
            checks++; if (m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1]) begin errors++; $display("FAIL cont_rdata i=%0d: got %h/%h want %h/%h", i, m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]); end
            step();
            if (i % 2 == 1) k1++; else k0++;
        end
        idle_all();
        step();
    endtask

    task automatic test_hold_under_stall();
        idle_all();
        drive(0, 32'h010, 4'h0, 1'b1, '0);
        #1;
        checks++; if (m0_stall !== 1'b0) begin errors++; $display("FAIL hold_c1_stall: got %b want 0", m0_stall); end
        step();
        drive(0, 32'h014, 4'h0, 1'b1, '0);
        drive(1, 32'h018, 4'h0, 1'b1, '0);
        #1;
        checks++; if ({m0_stall, m1_stall} !== 2'b10) begin errors++; $display("FAIL hold_c2_stalls: got %b want 10", {m0_stall, m1_stall}); end
        checks++; if (m0_rdata !== 32'h11111111) begin errors++; $display("FAIL hold_c2_rdata: got %h want 11111111", m0_rdata); end
        checks++; if (sram_addr !== 32'h018) begin errors++; $display("FAIL hold_c2_addr: got %h want 00000018", sram_addr); end
        step();
        drive(1, '0, 4'h0, 1'b0, '0);
        #1;
        checks++; if (m0_stall !== 1'b0 || sram_addr !== 32'h014) begin errors++; $display("FAIL hold_c3_grant: got stall=%b addr=%h want 0/00000014", m0_stall, sram_addr); end
        checks++; if (m0_rdata !== 32'h11111111) begin errors++; $display("FAIL hold_c3_rdata: got %h want 11111111", m0_rdata); end
        checks++; if (m1_rdata !== 32'h33333333) begin errors++; $display("FAIL hold_c3_m1_rdata: got %h want 33333333", m1_rdata); end
        step();
        idle_all();
        #1;
        checks++; if (m0_rdata !== 32'h22222222) begin errors++; $display("FAIL hold_c4_rdata: got %h want 22222222", m0_rdata); end
        step();
    endtask

    task automatic test_write_no_dphase();
        idle_all();
        drive(1, 32'h020, 4'h0, 1'b1, '0);
        #1;
        step();
        drive(1, 32'h020, 4'hF, 1'b0, 32'hCAFEF00D);
        #1;
        checks++; if (m1_rdata !== 32'h5) begin errors++; $display("FAIL wr_c2_rdata: got %h want 00000005", m1_rdata); end
        checks++; if (sram_wen !== 4'hF || sram_wdata !== 32'hCAFEF00D || sram_ren !== 1'b0) begin errors++; $display("FAIL wr_c2_sram: got wen=%h wdata=%h ren=%b want f/cafef00d/0", sram_wen, sram_wdata, sram_ren); end
        step();
        drive(1, 32'h020, 4'h0, 1'b1, '0);
        #1;
        checks++; if (m1_rdata !== 32'h5) begin errors++; $display("FAIL wr_c3_rdata: got %h want 00000005", m1_rdata); end
        step();
        idle_all();
        #1;
        checks++; if (m1_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_readback: got %h want cafef00d", m1_rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        idle_all();
        drive(0, 32'h100, 4'h0, 1'b1, '0);
        #1;
        step();
        drive(0, 32'h010, 4'h0, 1'b1, '0);
        rst_n = 1'b0;
        #1;
        checks++; if (sram_ren !== 1'b1 || sram_addr !== 32'h010) begin errors++; $display("FAIL rstmid_sram: got ren=%b addr=%h want 1/00000010", sram_ren, sram_addr); end
        step();
        rst_n = 1'b1;
        idle_all();
        #1;
        checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata); end
        drive(0, 32'h100, 4'h0, 1'b1, '0);
        drive(1, 32'h104, 4'h0, 1'b1, '0);
        #1;
        checks++; if ({m0_stall, m1_stall} !== 2'b01) begin errors++; $display("FAIL rstmid_first_contention: got %b want 01", {m0_stall, m1_stall}); end
        step();
        idle_all();
        #1;
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_post_read: got %h want deadbeef", m0_rdata); end
        step();
    endtask

    task automatic test_idle();
        idle_all();
        drive(0, 32'h100, 4'h0, 1'b1, '0);
        #1;
        step();
        for (int i = 0; i < 3; i++) begin
            idle_all();
            #1;
            checks++; if ({sram_ren, sram_wen, sram_addr, sram_wdata} !== '0) begin errors++; $display("FAIL idle_sram i=%0d: got ren=%b wen=%h addr=%h wdata=%h want zeros", i, sram_ren, sram_wen, sram_addr, sram_wdata); end
            checks++; if ({m0_stall, m1_stall} !== 2'b00) begin errors++; $display("FAIL idle_stalls i=%0d: got %b want 00", i, {m0_stall, m1_stall}); end
            step();
        end
        drive(0, 32'h100, 4'h0, 1'b1, '0);
        drive(1, 32'h104, 4'h0, 1'b1, '0);
        #1;
        checks++; if ({m0_stall, m1_stall} !== 2'b10) begin errors++; $display("FAIL idle_last_gnt_kept: got %b want 10", {m0_stall, m1_stall}); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_random();
        bit prev_stall [2] = '{1'b0, 1'b0};
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            for (int m = 0; m < 2; m++) begin
                if (!prev_stall[m]) begin
                    int kind;
                    logic [31:0] hi, addr;
                    kind = int'($urandom_range(0, 4));
                    hi   = $urandom & 32'hFFFF_FC00;
                    addr = hi | (32'h200 + 32'(4 * $urandom_range(0, 15)));
                    case (kind)
                        0:       drive(m, '0, 4'h0, 1'b0, '0);
                        1, 2:    drive(m, addr, 4'h0, 1'b1, '0);
                        3:       drive(m, addr, 4'($urandom_range(1, 15)), 1'b0, $urandom);
                        default: drive(m, addr, 4'($urandom_range(1, 15)), 1'b1, $urandom);
                    endcase
                end
            end
            #1;
            ref_eval();
            checks++; if (m0_stall !== exp_stall[0] || m1_stall !== exp_stall[1]) begin errors++; $display("FAIL rnd_stall i=%0d: got %b%b want %b%b", i, m0_stall, m1_stall, exp_stall[0], exp_stall[1]); end
            checks++; if (sram_addr !== exp_saddr) begin errors++; $display("FAIL rnd_addr i=%0d: got %h want %h", i, sram_addr, exp_saddr); end
            checks++; if (sram_wen !== exp_swen || sram_ren !== exp_sren) begin errors++; $display("FAIL rnd_en i=%0d: got wen=%h ren=%b want wen=%h ren=%b", i, sram_wen, sram_ren, exp_swen, exp_sren); end
            checks++; if (sram_wdata !== exp_swdata) begin errors++; $display("FAIL rnd_wdata i=%0d: got %h want %h", i, sram_wdata, exp_swdata); end
            checks++; if (m0_rdata !== exp_rdata[0]) begin errors++; $display("FAIL rnd_m0_rdata i=%0d: got %h want %h", i, m0_rdata, exp_rdata[0]); end
            checks++; if (m1_rdata !== exp_rdata[1]) begin errors++; $display("FAIL rnd_m1_rdata i=%0d: got %h want %h", i, m1_rdata, exp_rdata[1]); end
            prev_stall[0] = exp_stall[0];
            prev_stall[1] = exp_stall[1];
            step();
        end
        rst_n = 1'b1;
        idle_all();
        step();
    endtask

    initial begin
        preload();
        test_reset();
        test_solo_read();
        test_contention();
        test_hold_under_stall();
        test_write_no_dphase();
        test_reset_mid();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
